pipeline_hazard_ctrl: RTL and testbench

- Sequences the enables and bubble-inserts (flushes) of the five-stage pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves four hazard sources:
  - load-use data hazards
  - taken branches/jumps resolved in EX
  - multi-cycle multiply/divide occupancy of EX
  - data-memory wait states
- Sits beside the datapath. All pipeline Register instances take their enable from this block. Flush outputs drive the NOP-select muxes in front of those registers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_mdu_timer.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the datapath flush muxes.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 5;
    localparam int unsigned MDU_CNT_W      = 4;

    // Instruction word the flush muxes substitute for a bubble (sll $0,$0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        StRun,
        StMduWait
    } hz_state_e;

endpackage

// File: rtl/hazard_mdu_timer.sv
// Down-counter tracking the remaining stall cycles of a multi-cycle MDU operation in EX.
module hazard_mdu_timer
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [MDU_CNT_W-1:0] load_val,
    input  logic                 run,
    output logic                 zero
);

    logic [MDU_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enable/flush sequencing for load-use, taken-branch, MDU occupancy and memory waits.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mdu_start,
    input  logic                  mem_wait,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_flush,
    output logic                  exmem_en,
    output logic                  exmem_flush,
    output logic                  memwb_en,
    output logic                  mdu_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [MDU_CNT_W-1:0] MduInit = MDU_CNT_W'(MDU_LATENCY - 1);

    hz_state_e        state_q;
    logic             in_run;
    logic             mdu_zero;
    logic             mdu_load;
    logic             mdu_stall;
    logic             load_use;
    logic [CNT_W-1:0] stall_q;

    assign in_run    = (state_q == StRun);
    assign mdu_load  = in_run && ex_mdu_start && !mem_wait;
    assign mdu_stall = (in_run && ex_mdu_start) || (!in_run && !mdu_zero);
    assign load_use  = ex_mem_read && (ex_rt != '0) &&
                       ((id_rs == ex_rt) || (id_uses_rt && (id_rt == ex_rt)));

    hazard_mdu_timer u_mdu_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (mdu_load),
        .load_val (MduInit),
        .run      (!in_run),
        .zero     (mdu_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun:     if (mdu_load) state_q <= StMduWait;
                StMduWait: if (mdu_zero) state_q <= StRun;
                default:   state_q <= StRun;
            endcase
        end
    end

    // Inputs are don't-care while reset is held, so present a free-running pipeline.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        if (!reset) begin
            pc_en = 1'b1;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mdu_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (!pc_en && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign mdu_busy     = !in_run;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut_a uses MDU_LATENCY=4/CNT_W=16, dut_b uses MDU_LATENCY=1/CNT_W=4.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] IDLE   = 8'hD5;
    localparam logic [7:0] FREEZE = 8'h00;
    localparam logic [7:0] MDU    = 8'h07;
    localparam logic [7:0] BRANCH = 8'hFD;
    localparam logic [7:0] LDUSE  = 8'h1D;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_mdu_start, mem_wait;
    logic [4:0] b_id_rs, b_id_rt, b_ex_rt;
    logic       b_id_uses_rt, b_ex_mem_read, b_ex_branch_taken, b_ex_mdu_start, b_mem_wait;

    logic a_pc, a_ifid, a_ifidf, a_idex, a_idexf, a_exmem, a_exmemf, a_memwb, a_busy;
    logic b_pc, b_ifid, b_ifidf, b_idex, b_idexf, b_exmem, b_exmemf, b_memwb, b_busy;
    logic [15:0] a_stall;
    logic [3:0]  b_stall;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MDU_LATENCY(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mem_wait(mem_wait), .pc_en(a_pc), .ifid_en(a_ifid),
        .ifid_flush(a_ifidf), .idex_en(a_idex), .idex_flush(a_idexf), .exmem_en(a_exmem),
        .exmem_flush(a_exmemf), .memwb_en(a_memwb), .mdu_busy(a_busy), .stall_cycles(a_stall)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MDU_LATENCY(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_rs(b_id_rs), .id_rt(b_id_rt), .id_uses_rt(b_id_uses_rt),
        .ex_mem_read(b_ex_mem_read), .ex_rt(b_ex_rt), .ex_branch_taken(b_ex_branch_taken),
        .ex_mdu_start(b_ex_mdu_start), .mem_wait(b_mem_wait), .pc_en(b_pc), .ifid_en(b_ifid),
        .ifid_flush(b_ifidf), .idex_en(b_idex), .idex_flush(b_idexf), .exmem_en(b_exmem),
        .exmem_flush(b_exmemf), .memwb_en(b_memwb), .mdu_busy(b_busy), .stall_cycles(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [7:0] outs, input logic busy,
                            input int stall);
        #1;
        chk({tag, " a.en/flush"}, {24'd0, a_pc, a_ifid, a_ifidf, a_idex, a_idexf,
                                   a_exmem, a_exmemf, a_memwb}, {24'd0, outs});
        chk({tag, " a.busy"}, {31'd0, a_busy}, {31'd0, busy});
        chk({tag, " a.stall"}, {16'd0, a_stall}, 32'(stall));
    endtask

    task automatic expect_b(input string tag, input logic [7:0] outs, input logic busy,
                            input int stall);
        #1;
        chk({tag, " b.en/flush"}, {24'd0, b_pc, b_ifid, b_ifidf, b_idex, b_idexf,
                                   b_exmem, b_exmemf, b_memwb}, {24'd0, outs});
        chk({tag, " b.busy"}, {31'd0, b_busy}, {31'd0, busy});
        chk({tag, " b.stall"}, {28'd0, b_stall}, 32'(stall));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic idle_b();
        b_id_rs = 5'd0; b_id_rt = 5'd0; b_ex_rt = 5'd0; b_id_uses_rt = 1'b0;
        b_ex_mem_read = 1'b0; b_ex_branch_taken = 1'b0; b_ex_mdu_start = 1'b0; b_mem_wait = 1'b0;
    endtask

    task automatic randomize_inputs();
        id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
        {id_uses_rt, ex_mem_read, ex_branch_taken, ex_mdu_start, mem_wait} = 5'($urandom);
        b_id_rs = 5'($urandom); b_id_rt = 5'($urandom); b_ex_rt = 5'($urandom);
        {b_id_uses_rt, b_ex_mem_read, b_ex_branch_taken, b_ex_mdu_start, b_mem_wait} =
            5'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        idle_a();
        idle_b();
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            expect_a("reset", IDLE, 1'b0, 0);
            expect_b("reset", IDLE, 1'b0, 0);
            tick();
        end
        idle_a();
        idle_b();
        reset = 1'b1;
        expect_a("idle", IDLE, 1'b0, 0);
        expect_b("idle", IDLE, 1'b0, 0);
        tick();

        // Load-use on rs, then on rt, and the no-hazard variants.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        expect_a("lduse_rs", LDUSE, 1'b0, 0);
        tick();
        idle_a();
        expect_a("lduse_after", IDLE, 1'b0, 1);
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        expect_a("lduse_r0", IDLE, 1'b0, 1);
        tick();
        ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
        expect_a("lduse_rt", LDUSE, 1'b0, 1);
        tick();
        id_uses_rt = 1'b0;
        expect_a("lduse_rt_unused", IDLE, 1'b0, 2);
        tick();
        idle_a();

        // MDU op with MDU_LATENCY=4, start held until the op leaves EX.
        ex_mdu_start = 1'b1;
        expect_a("mdu0", MDU, 1'b0, 2); tick();
        expect_a("mdu1", MDU, 1'b1, 3); tick();
        expect_a("mdu2", MDU, 1'b1, 4); tick();
        expect_a("mdu3", MDU, 1'b1, 5); tick();
        expect_a("mdu_rel", IDLE, 1'b1, 6); tick();
        ex_mdu_start = 1'b0;
        expect_a("mdu_done", IDLE, 1'b0, 6); tick();

        // Taken branch wins over a simultaneous load-use.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        expect_a("br_lduse", BRANCH, 1'b0, 6); tick();
        idle_a();
        expect_a("br_after", IDLE, 1'b0, 6); tick();

        // mem_wait inside MDU_WAIT: counter keeps running under the freeze.
        ex_mdu_start = 1'b1;
        expect_a("mw_mdu0", MDU, 1'b0, 6); tick();
        expect_a("mw_mdu1", MDU, 1'b1, 7); tick();
        mem_wait = 1'b1;
        expect_a("mw_frz_c2", FREEZE, 1'b1, 8); tick();
        expect_a("mw_frz_c1", FREEZE, 1'b1, 9); tick();
        mem_wait = 1'b0;
        expect_a("mw_rel", IDLE, 1'b1, 10); tick();
        ex_mdu_start = 1'b0;
        expect_a("mw_done", IDLE, 1'b0, 10); tick();

        // mem_wait on the MDU start cycle delays the count.
        ex_mdu_start = 1'b1; mem_wait = 1'b1;
        expect_a("mws_frz", FREEZE, 1'b0, 10); tick();
        mem_wait = 1'b0;
        expect_a("mws_0", MDU, 1'b0, 11); tick();
        expect_a("mws_1", MDU, 1'b1, 12); tick();
        expect_a("mws_2", MDU, 1'b1, 13); tick();
        expect_a("mws_3", MDU, 1'b1, 14); tick();
        expect_a("mws_rel", IDLE, 1'b1, 15); tick();
        ex_mdu_start = 1'b0;
        expect_a("mws_done", IDLE, 1'b0, 15); tick();

        // mem_wait overrides a branch flush; the flush follows once the wait ends.
        mem_wait = 1'b1; ex_branch_taken = 1'b1;
        expect_a("mw_br", FREEZE, 1'b0, 15); tick();
        mem_wait = 1'b0;
        expect_a("br_post_mw", BRANCH, 1'b0, 16); tick();
        idle_a();

        // MDU_LATENCY=1: single stall cycle.
        b_ex_mdu_start = 1'b1;
        expect_b("lat1_0", MDU, 1'b0, 0); tick();
        expect_b("lat1_rel", IDLE, 1'b1, 1); tick();
        b_ex_mdu_start = 1'b0;
        expect_b("lat1_done", IDLE, 1'b0, 1); tick();

        // 4-bit stall counter saturates at 15.
        b_mem_wait = 1'b1;
        for (int k = 0; k < 16; k++) begin
            expect_b("sat", FREEZE, 1'b0, (k + 1 > 15) ? 15 : k + 1);
            tick();
        end
        b_mem_wait = 1'b0;
        expect_b("sat_hold", IDLE, 1'b0, 15);

        // Reset mid-MDU stall abandons the op immediately.
        ex_mdu_start = 1'b1;
        expect_a("rst_mdu0", MDU, 1'b0, 16); tick();
        expect_a("rst_mdu1", MDU, 1'b1, 17); tick();
        reset = 1'b0;
        expect_a("rst_mid", IDLE, 1'b0, 0);
        expect_b("rst_mid", IDLE, 1'b0, 0);
        tick();
        reset = 1'b1;
        ex_mdu_start = 1'b0;
        expect_a("rst_post", IDLE, 1'b0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
